// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator.
// Event kinds, controller numbers, FSM states, event bundle.
package synth_pkg;

  typedef enum logic [1:0] {
    EV_NOTE_ON  = 2'd0,
    EV_NOTE_OFF = 2'd1,
    EV_CTRL     = 2'd2,
    EV_IGNORE   = 2'd3
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MATCH,
    ST_COMMIT,
    ST_SWEEP
  } state_e;

  localparam logic [6:0] CC_SUSTAIN       = 7'd64;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [7:0] KEY_EMPTY        = 8'hff;

  typedef struct packed {
    ev_type_e   typ;
    logic [3:0] chan;
    logic [6:0] d1;
    logic [6:0] d2;
  } event_t;

endpackage

// File: rtl/voice_select.sv
// Combinational voice search: retrigger, free, idle, then oldest.
// Oldest pick only counts as found when VOICE_STEAL_EN is defined.
module voice_select
  import synth_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic [7:0]         i_note [VOICES],
  input  logic [3:0]         i_chan [VOICES],
  input  logic [V_WIDTH:0]   i_age  [VOICES],
  input  logic [VOICES-1:0]  i_gate,
  input  logic [VOICES-1:0]  i_free,
  input  logic [3:0]         i_ev_chan,
  input  logic [6:0]         i_ev_note,
  input  logic               i_is_off,
  input  logic               i_mono,
  output logic [V_WIDTH-1:0] o_idx,
  output logic               o_found
);

  logic [V_WIDTH-1:0] w_hit_idx;
  logic [V_WIDTH-1:0] w_free_idx;
  logic [V_WIDTH-1:0] w_idle_idx;
  logic [V_WIDTH-1:0] w_old_idx;
  logic [V_WIDTH:0]   w_old_age;
  logic               w_hit;
  logic               w_free;
  logic               w_idle;
  logic               w_v0_hit;

  // downward scans so the lowest index wins
  always_comb begin
    w_hit      = 1'b0;
    w_free     = 1'b0;
    w_idle     = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_idle_idx = '0;
    w_old_idx  = '0;
    w_old_age  = '0;
    for (int i = VOICES-1; i >= 0; i--) begin
      if (i_note[i] == {1'b0, i_ev_note} &&
          i_chan[i] == i_ev_chan) begin
        w_hit     = 1'b1;
        w_hit_idx = V_WIDTH'(i);
      end
      if (!i_gate[i] && i_free[i]) begin
        w_free     = 1'b1;
        w_free_idx = V_WIDTH'(i);
      end
      if (!i_gate[i]) begin
        w_idle     = 1'b1;
        w_idle_idx = V_WIDTH'(i);
      end
      if (i_gate[i] && i_age[i] >= w_old_age) begin
        w_old_age = i_age[i];
        w_old_idx = V_WIDTH'(i);
      end
    end
  end

  assign w_v0_hit = (i_note[0] == {1'b0, i_ev_note}) &&
                    (i_chan[0] == i_ev_chan);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    if (i_mono) begin
      o_idx   = '0;
      o_found = i_is_off ? w_v0_hit : 1'b1;
    end else if (i_is_off) begin
      o_idx   = w_hit_idx;
      o_found = w_hit;
    end else if (w_hit) begin
      o_idx   = w_hit_idx;
      o_found = 1'b1;
    end else if (w_free) begin
      o_idx   = w_free_idx;
      o_found = 1'b1;
    end else if (w_idle) begin
      o_idx   = w_idle_idx;
      o_found = 1'b1;
    end else begin
      o_idx   = w_old_idx;
`ifdef VOICE_STEAL_EN
      o_found = 1'b1;
`else
      o_found = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator with sustain, sweeps and mono mode.
// Define VOICE_STEAL_EN to steal the oldest voice when all are gated.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               reg_clk,
  input  logic               reset_reg_N,
  input  logic [VOICES-1:0]  voice_free,
  input  logic [15:0]        chan_mask,
  input  logic               mono_mode,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [1:0]         ev_type,
  input  logic [3:0]         ev_chan,
  input  logic [6:0]         ev_data1,
  input  logic [6:0]         ev_data2,
  output logic [VOICES-1:0]  keys_on,
  output logic               key_upd,
  output logic [V_WIDTH-1:0] key_adr,
  output logic [7:0]         key_val,
  output logic [6:0]         key_vel,
  output logic [3:0]         key_chan,
  output logic [V_WIDTH:0]   active_keys,
  output logic               drop
);

  localparam logic [V_WIDTH:0]   AGE_MAX = (V_WIDTH+1)'(VOICES);
  localparam logic [V_WIDTH-1:0] LAST    = V_WIDTH'(VOICES-1);

  state_e             r_state;
  event_t             r_ev;
  logic               r_ready;
  logic               r_sweep_all;
  logic [V_WIDTH-1:0] r_idx;
  logic [VOICES-1:0]  r_free_s1;
  logic [VOICES-1:0]  r_free_s2;
  logic [7:0]         r_note  [VOICES];
  logic [3:0]         r_vchan [VOICES];
  logic [V_WIDTH:0]   r_age   [VOICES];
  logic [VOICES-1:0]  r_gate;
  logic [VOICES-1:0]  r_held;
  logic [15:0]        r_sus;
  logic [V_WIDTH:0]   r_active;
  logic               r_upd;
  logic [V_WIDTH-1:0] r_adr;
  logic [7:0]         r_val;
  logic [6:0]         r_vel;
  logic [3:0]         r_kchan;
  logic               r_drop;

  event_t             w_ev;
  logic [V_WIDTH-1:0] w_sel;
  logic               w_found;
  logic               w_on;
  logic               w_off;
  logic               w_sw_hit;

  // masked channels and zero-velocity note-ons are folded here
  always_comb begin
    w_ev.typ  = ev_type_e'(ev_type);
    w_ev.chan = ev_chan;
    w_ev.d1   = ev_data1;
    w_ev.d2   = ev_data2;
    if (!chan_mask[ev_chan]) begin
      w_ev.typ = EV_IGNORE;
    end else if (w_ev.typ == EV_NOTE_ON &&
                 ev_data2 == 7'd0) begin
      w_ev.typ = EV_NOTE_OFF;
      w_ev.d2  = 7'd64;
    end
  end

  assign w_on  = (r_ev.typ == EV_NOTE_ON);
  assign w_off = (r_ev.typ == EV_NOTE_OFF);

  assign w_sw_hit = (r_vchan[r_idx] == r_ev.chan) &&
                    (r_sweep_all ? r_gate[r_idx]
                                 : r_held[r_idx]);

  voice_select #(
    .VOICES  (VOICES),
    .V_WIDTH (V_WIDTH)
  ) u_sel (
    .i_note    (r_note),
    .i_chan    (r_vchan),
    .i_age     (r_age),
    .i_gate    (r_gate),
    .i_free    (r_free_s2),
    .i_ev_chan (r_ev.chan),
    .i_ev_note (r_ev.d1),
    .i_is_off  (w_off),
    .i_mono    (mono_mode),
    .o_idx     (w_sel),
    .o_found   (w_found)
  );

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_free_s1 <= '0;
      r_free_s2 <= '0;
    end else begin
      r_free_s1 <= voice_free;
      r_free_s2 <= r_free_s1;
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_state     <= ST_IDLE;
      r_ev        <= '0;
      r_ready     <= 1'b0;
      r_sweep_all <= 1'b0;
      r_idx       <= '0;
      r_gate      <= '0;
      r_held      <= '0;
      r_sus       <= '0;
      r_active    <= '0;
      r_upd       <= 1'b0;
      r_adr       <= '0;
      r_val       <= KEY_EMPTY;
      r_vel       <= '0;
      r_kchan     <= '0;
      r_drop      <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        r_note[i]  <= KEY_EMPTY;
        r_vchan[i] <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      r_upd  <= 1'b0;
      r_drop <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (ev_valid) begin
            r_ready <= 1'b0;
            r_ev    <= w_ev;
            r_idx   <= '0;
            r_state <= ST_MATCH;
            if (w_ev.typ == EV_CTRL &&
                w_ev.d1 == CC_SUSTAIN) begin
              r_sus[w_ev.chan] <= w_ev.d2[6];
              if (r_sus[w_ev.chan] && !w_ev.d2[6]) begin
                r_state     <= ST_SWEEP;
                r_sweep_all <= 1'b0;
              end
            end else if (w_ev.typ == EV_CTRL &&
                         w_ev.d1 == CC_ALL_NOTES_OFF) begin
              r_state     <= ST_SWEEP;
              r_sweep_all <= 1'b1;
            end
          end
        end

        ST_MATCH: begin
          r_state <= ST_COMMIT;
          unique case (1'b1)
            w_on && w_found: begin
              for (int i = 0; i < VOICES; i++) begin
                if (V_WIDTH'(i) == w_sel) begin
                  r_note[i]  <= {1'b0, r_ev.d1};
                  r_vchan[i] <= r_ev.chan;
                  r_gate[i]  <= 1'b1;
                  r_held[i]  <= 1'b0;
                  r_age[i]   <= '0;
                end else if (r_gate[i] &&
                             r_age[i] != AGE_MAX) begin
                  r_age[i] <= r_age[i] + 1'b1;
                end
              end
              if (!r_gate[w_sel])
                r_active <= r_active + 1'b1;
              r_upd   <= 1'b1;
              r_adr   <= w_sel;
              r_val   <= {1'b0, r_ev.d1};
              r_vel   <= r_ev.d2;
              r_kchan <= r_ev.chan;
            end
            w_on && !w_found: begin
              r_drop <= 1'b1;
            end
            w_off && w_found: begin
              if (r_sus[r_ev.chan]) begin
                r_held[w_sel] <= 1'b1;
              end else begin
                r_gate[w_sel] <= 1'b0;
                r_held[w_sel] <= 1'b0;
                r_note[w_sel] <= KEY_EMPTY;
                r_age[w_sel]  <= '0;
                r_active      <= r_active - 1'b1;
                r_upd         <= 1'b1;
                r_adr         <= w_sel;
                r_val         <= KEY_EMPTY;
                r_vel         <= r_ev.d2;
                r_kchan       <= r_vchan[w_sel];
              end
            end
            default: ;
          endcase
        end

        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end

        ST_SWEEP: begin
          if (w_sw_hit) begin
            r_gate[r_idx] <= 1'b0;
            r_held[r_idx] <= 1'b0;
            r_note[r_idx] <= KEY_EMPTY;
            r_age[r_idx]  <= '0;
            r_active      <= r_active - 1'b1;
            r_upd         <= 1'b1;
            r_adr         <= r_idx;
            r_val         <= KEY_EMPTY;
            r_vel         <= '0;
            r_kchan       <= r_ev.chan;
          end
          if (r_idx == LAST) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ev_ready    = r_ready;
  assign keys_on     = r_gate;
  assign key_upd     = r_upd;
  assign key_adr     = r_adr;
  assign key_val     = r_val;
  assign key_vel     = r_vel;
  assign key_chan    = r_kchan;
  assign active_keys = r_active;
  assign drop        = r_drop;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed vector bench for voice_allocator with four voices.
// Expectations follow VOICE_STEAL_EN when the macro is defined.
module tb_voice_allocator;

  localparam int VOICES  = 4;
  localparam int V_WIDTH = 2;
`ifdef VOICE_STEAL_EN
  localparam int XN = 70;
`else
  localparam int XN = 60;
`endif

  logic         reg_clk = 1'b0;
  logic         reset_reg_N;
  logic [3:0]   voice_free;
  logic [15:0]  chan_mask;
  logic         mono_mode;
  logic         ev_valid;
  logic         ev_ready;
  logic [1:0]   ev_type;
  logic [3:0]   ev_chan;
  logic [6:0]   ev_data1;
  logic [6:0]   ev_data2;
  logic [3:0]   keys_on;
  logic         key_upd;
  logic [1:0]   key_adr;
  logic [7:0]   key_val;
  logic [6:0]   key_vel;
  logic [3:0]   key_chan;
  logic [2:0]   active_keys;
  logic         drop;

  int n_checks = 0;
  int n_err    = 0;

  always #5 reg_clk = ~reg_clk;

  voice_allocator #(
    .VOICES  (VOICES),
    .V_WIDTH (V_WIDTH)
  ) dut (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .voice_free  (voice_free),
    .chan_mask   (chan_mask),
    .mono_mode   (mono_mode),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_type     (ev_type),
    .ev_chan     (ev_chan),
    .ev_data1    (ev_data1),
    .ev_data2    (ev_data2),
    .keys_on     (keys_on),
    .key_upd     (key_upd),
    .key_adr     (key_adr),
    .key_val     (key_val),
    .key_vel     (key_vel),
    .key_chan    (key_chan),
    .active_keys (active_keys),
    .drop        (drop)
  );

  typedef struct {
    logic        mono;
    logic [15:0] mask;
    logic [3:0]  free;
    logic [1:0]  typ;
    logic [3:0]  chan;
    logic [6:0]  d1;
    logic [6:0]  d2;
    logic        sw;
    logic [3:0]  swm;
    logic        upd;
    logic [1:0]  adr;
    logic [7:0]  val;
    logic [6:0]  vel;
    logic [3:0]  kch;
    logic [3:0]  keys;
    logic [2:0]  act;
    logic        drp;
  } vec_t;

  vec_t tv [24];

  function automatic vec_t mk(
    int mono, int mask, int free, int typ, int chan,
    int d1, int d2, int sw, int swm, int upd, int adr,
    int val, int vel, int kch, int keys, int act, int drp);
    vec_t v;
    v.mono = mono[0];     v.mask = mask[15:0];
    v.free = free[3:0];   v.typ  = typ[1:0];
    v.chan = chan[3:0];   v.d1   = d1[6:0];
    v.d2   = d2[6:0];     v.sw   = sw[0];
    v.swm  = swm[3:0];    v.upd  = upd[0];
    v.adr  = adr[1:0];    v.val  = val[7:0];
    v.vel  = vel[6:0];    v.kch  = kch[3:0];
    v.keys = keys[3:0];   v.act  = act[2:0];
    v.drp  = drp[0];
    return v;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // returns #1 after the accepting edge, i.e. in cycle T+1
  task automatic send(input logic [1:0] t, input logic [3:0] c,
                      input logic [6:0] a, input logic [6:0] b);
    int n;
    @(negedge reg_clk);
    ev_valid = 1'b1;
    ev_type  = t;
    ev_chan  = c;
    ev_data1 = a;
    ev_data2 = b;
    n = 0;
    while (!ev_ready && n < 20) begin
      @(negedge reg_clk);
      n++;
    end
    if (!ev_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(posedge reg_clk);
    #1;
    ev_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = mk(0,'hffff,'hf,0,0,60,100,0,0, 1,0,60,100,0,'b0001,1,0);
    tv[1]  = mk(0,'hffff,'hf,0,0,62,101,0,0, 1,1,62,101,0,'b0011,2,0);
    tv[2]  = mk(0,'hffff,'hf,0,0,64,102,0,0, 1,2,64,102,0,'b0111,3,0);
    tv[3]  = mk(0,'hffff,'hf,0,0,65,103,0,0, 1,3,65,103,0,'b1111,4,0);
`ifdef VOICE_STEAL_EN
    tv[4]  = mk(0,'hffff,'hf,0,0,70,90,0,0,  1,0,70,90,0,'b1111,4,0);
`else
    tv[4]  = mk(0,'hffff,'hf,0,0,70,90,0,0,  0,0,0,0,0,'b1111,4,1);
`endif
    tv[5]  = mk(0,'hffff,'hf,1,0,62,30,0,0,  1,1,'hff,30,0,'b1101,3,0);
    tv[6]  = mk(0,'hffff,'hf,0,0,64,0,0,0,   1,2,'hff,64,0,'b1001,2,0);
    tv[7]  = mk(0,'hffff,'hf,0,0,66,50,0,0,  1,1,66,50,0,'b1011,3,0);
    tv[8]  = mk(0,'hffff,'hf,0,0,65,77,0,0,  1,3,65,77,0,'b1011,3,0);
    tv[9]  = mk(0,'hffff,'hf,2,0,7,5,0,0,    0,0,0,0,0,'b1011,3,0);
    tv[10] = mk(0,'hffff,'hf,3,0,60,1,0,0,   0,0,0,0,0,'b1011,3,0);
    tv[11] = mk(0,'hffff,'hf,2,0,64,127,0,0, 0,0,0,0,0,'b1011,3,0);
    tv[12] = mk(0,'hffff,'hf,1,0,XN,10,0,0,  0,0,0,0,0,'b1011,3,0);
    tv[13] = mk(0,'hffff,'hf,2,0,64,0,1,'b0001, 0,0,0,0,0,'b1010,2,0);
    tv[14] = mk(0,'hffff,'b0100,0,0,50,55,0,0, 1,2,50,55,0,'b1110,3,0);
    tv[15] = mk(0,'h0001,'hf,0,1,60,100,0,0, 0,0,0,0,0,'b1110,3,0);
    tv[16] = mk(0,'hffff,'hf,1,1,50,1,0,0,   0,0,0,0,0,'b1110,3,0);
    tv[17] = mk(0,'hffff,'hf,2,0,123,0,1,'b1110, 0,0,0,0,0,'b0000,0,0);
    tv[18] = mk(1,'hffff,'hf,0,0,60,100,0,0, 1,0,60,100,0,'b0001,1,0);
    tv[19] = mk(1,'hffff,'hf,0,0,67,80,0,0,  1,0,67,80,0,'b0001,1,0);
    tv[20] = mk(1,'hffff,'hf,1,0,60,5,0,0,   0,0,0,0,0,'b0001,1,0);
    tv[21] = mk(1,'hffff,'hf,1,0,67,20,0,0,  1,0,'hff,20,0,'b0000,0,0);
    tv[22] = mk(0,'hffff,'hf,0,5,72,33,0,0,  1,0,72,33,5,'b0001,1,0);
    tv[23] = mk(0,'hffff,'hf,2,5,123,0,1,'b0001, 0,0,0,0,5,'b0000,0,0);

    reset_reg_N = 1'b0;
    voice_free  = 4'hf;
    chan_mask   = 16'hffff;
    mono_mode   = 1'b0;
    ev_valid    = 1'b0;
    ev_type     = 2'd0;
    ev_chan     = 4'd0;
    ev_data1    = 7'd0;
    ev_data2    = 7'd0;

    repeat (3) @(posedge reg_clk);
    #1;
    check("rst keys_on", keys_on, 0);
    check("rst key_val", key_val, 8'hff);
    check("rst ev_ready", ev_ready, 0);
    check("rst active", active_keys, 0);
    check("rst key_upd", key_upd, 0);
    check("rst drop", drop, 0);
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    @(posedge reg_clk);
    #1;
    check("rst ready_back", ev_ready, 1);

    for (int n = 0; n < 24; n++) begin
      @(negedge reg_clk);
      mono_mode  = tv[n].mono;
      chan_mask  = tv[n].mask;
      voice_free = tv[n].free;
      repeat (3) @(negedge reg_clk);
      send(tv[n].typ, tv[n].chan, tv[n].d1, tv[n].d2);
      check($sformatf("v%0d upd_t1", n), key_upd, 0);
      if (tv[n].sw) begin
        for (int k = 1; k <= VOICES + 1; k++) begin
          logic eu;
          if (k > 1) begin
            @(posedge reg_clk);
            #1;
          end
          eu = (k >= 2) ? tv[n].swm[k-2] : 1'b0;
          check($sformatf("v%0d sw%0d upd", n, k), key_upd, eu);
          if (eu) begin
            check($sformatf("v%0d sw%0d adr", n, k), key_adr, k - 2);
            check($sformatf("v%0d sw%0d val", n, k), key_val, 8'hff);
            check($sformatf("v%0d sw%0d chan", n, k), key_chan, tv[n].kch);
          end
          check($sformatf("v%0d sw%0d ready", n, k), ev_ready,
                (k == VOICES + 1) ? 1 : 0);
        end
        check($sformatf("v%0d keys", n), keys_on, tv[n].keys);
        check($sformatf("v%0d active", n), active_keys, tv[n].act);
      end else begin
        @(posedge reg_clk);
        #1;
        check($sformatf("v%0d upd", n), key_upd, tv[n].upd);
        check($sformatf("v%0d drop", n), drop, tv[n].drp);
        check($sformatf("v%0d keys", n), keys_on, tv[n].keys);
        check($sformatf("v%0d active", n), active_keys, tv[n].act);
        check($sformatf("v%0d ready_t2", n), ev_ready, 0);
        if (tv[n].upd) begin
          check($sformatf("v%0d adr", n), key_adr, tv[n].adr);
          check($sformatf("v%0d val", n), key_val, tv[n].val);
          check($sformatf("v%0d vel", n), key_vel, tv[n].vel);
          check($sformatf("v%0d chan", n), key_chan, tv[n].kch);
        end
        @(posedge reg_clk);
        #1;
        check($sformatf("v%0d ready_t3", n), ev_ready, 1);
        check($sformatf("v%0d upd_t3", n), key_upd, 0);
        check($sformatf("v%0d drop_t3", n), drop, 0);
      end
    end

    // reset in the middle of an all-notes-off sweep
    send(2'd0, 4'd0, 7'd40, 7'd90);
    @(posedge reg_clk);
    #1;
    @(posedge reg_clk);
    #1;
    check("mid keys_before", keys_on, 4'b0001);
    send(2'd2, 4'd0, 7'd123, 7'd0);
    @(posedge reg_clk);
    #1;
    check("mid sweep_upd", key_upd, 1);
    reset_reg_N = 1'b0;
    #1;
    check("mid keys_on", keys_on, 0);
    check("mid key_val", key_val, 8'hff);
    check("mid ev_ready", ev_ready, 0);
    check("mid key_upd", key_upd, 0);
    check("mid active", active_keys, 0);
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    @(posedge reg_clk);
    #1;
    check("mid ready_back", ev_ready, 1);
    check("mid upd_after", key_upd, 0);
    @(posedge reg_clk);
    #1;
    check("mid upd_after2", key_upd, 0);
    check("mid keys_after", keys_on, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
